axi4lite_slave_regs: RTL and testbench

AXI4LITE_SLAVE_REGS -- requirements
Module: axi4lite_slave_regs

---
 rtl/axi4lite_slave_regs.sv | 162 ++++++++++++++++
 tb/tb_axi4lite_slave_regs.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave with a four-entry 8-bit register map: CTRL, DATA, SCRATCH (RW) and STATUS (RO).
// Write and read channels run as independent FSMs; writes commit on the edge that enters W_RESP.
module axi4lite_slave_regs (
    input  logic       s_axi_aclk,
    input  logic       s_axi_aresetn,
    input  logic [1:0] s_axi_awaddr,
    input  logic       s_axi_awvalid,
    output logic       s_axi_awready,
    input  logic [7:0] s_axi_wdata,
    input  logic       s_axi_wstrb,
    input  logic       s_axi_wvalid,
    output logic       s_axi_wready,
    output logic [1:0] s_axi_bresp,
    output logic       s_axi_bvalid,
    input  logic       s_axi_bready,
    input  logic [1:0] s_axi_araddr,
    input  logic       s_axi_arvalid,
    output logic       s_axi_arready,
    output logic [7:0] s_axi_rdata,
    output logic [1:0] s_axi_rresp,
    output logic       s_axi_rvalid,
    input  logic       s_axi_rready,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic [7:0] data_out,
    output logic       data_wr_pulse
);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    localparam logic [1:0] IDX_DATA   = 2'd1;
    localparam logic [1:0] IDX_STATUS = 2'd3;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wstate_t    wstate_q, wstate_d;
    rstate_t    rstate_q, rstate_d;
    logic       ready_en_q;
    logic [1:0] awaddr_q;
    logic [7:0] wdata_q;
    logic       wstrb_q;
    logic [7:0] regs_q [0:2];
    logic [1:0] bresp_q;
    logic [7:0] rdata_q, rdata_d;
    logic       pulse_q;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic       commit;
    logic [1:0] commit_addr;
    logic [7:0] commit_data;
    logic       commit_strb;
    logic       commit_reg_wr;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign b_hs  = s_axi_bvalid && s_axi_bready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign r_hs  = s_axi_rvalid && s_axi_rready;

    // Address/data may arrive on the commit edge itself, so bypass the latches then.
    assign commit        = (wstate_d == W_RESP) && (wstate_q != W_RESP);
    assign commit_addr   = aw_hs ? s_axi_awaddr : awaddr_q;
    assign commit_data   = w_hs ? s_axi_wdata : wdata_q;
    assign commit_strb   = w_hs ? s_axi_wstrb : wstrb_q;
    assign commit_reg_wr = commit && commit_strb && (commit_addr != IDX_STATUS);

    // State registers
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wstate_q   <= W_IDLE;
            rstate_q   <= R_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            rstate_q   <= rstate_d;
            ready_en_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wstate_d = W_RESP;
                else if (aw_hs)    wstate_d = W_ADDR;
                else if (w_hs)     wstate_d = W_DATA;
            end
            W_ADDR:  if (w_hs)  wstate_d = W_RESP;
            W_DATA:  if (aw_hs) wstate_d = W_RESP;
            W_RESP:  if (b_hs)  wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs) rstate_d = R_DATA;
            R_DATA:  if (r_hs)  rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Outputs decoded from registered state; readies stay low until the first edge out of reset.
    always_comb begin
        s_axi_awready = ready_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_DATA));
        s_axi_wready  = ready_en_q && ((wstate_q == W_IDLE) || (wstate_q == W_ADDR));
        s_axi_bvalid  = (wstate_q == W_RESP);
        s_axi_arready = ready_en_q && (rstate_q == R_IDLE);
        s_axi_rvalid  = (rstate_q == R_DATA);
    end

    assign s_axi_bresp   = bresp_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = RESP_OKAY;
    assign ctrl_out      = regs_q[0];
    assign data_out      = regs_q[1];
    assign data_wr_pulse = pulse_q;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            awaddr_q <= 2'd0;
            wdata_q  <= 8'h00;
            wstrb_q  <= 1'b0;
            bresp_q  <= RESP_OKAY;
            pulse_q  <= 1'b0;
        end else begin
            if (aw_hs) awaddr_q <= s_axi_awaddr;
            if (w_hs) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) bresp_q <= (commit_addr == IDX_STATUS) ? RESP_SLVERR : RESP_OKAY;
            pulse_q <= commit_reg_wr && (commit_addr == IDX_DATA);
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_regs
        always_ff @(posedge s_axi_aclk) begin
            if (!s_axi_aresetn)                                   regs_q[gi] <= 8'h00;
            else if (commit_reg_wr && (commit_addr == 2'(gi)))    regs_q[gi] <= commit_data;
        end
    end

    // Reads sample pre-commit register contents, so a same-edge write is not visible.
    always_comb begin
        case (s_axi_araddr)
            2'd0:    rdata_d = regs_q[0];
            2'd1:    rdata_d = regs_q[1];
            2'd2:    rdata_d = regs_q[2];
            default: rdata_d = status_in;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn)  rdata_q <= 8'h00;
        else if (ar_hs)      rdata_q <= rdata_d;
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: directed scenarios plus randomized
// transactions compared against an array model of the register map.
module tb_axi4lite_slave_regs;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [1:0] awaddr;
    logic       awvalid;
    logic       awready;
    logic [7:0] wdata;
    logic       wstrb;
    logic       wvalid;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       bready;
    logic [1:0] araddr;
    logic       arvalid;
    logic       arready;
    logic [7:0] rdata;
    logic [1:0] rresp;
    logic       rvalid;
    logic       rready;
    logic [7:0] status_in;
    logic [7:0] ctrl_out;
    logic [7:0] data_out;
    logic       data_wr_pulse;

    int errors = 0;
    int checks = 0;
    logic [7:0] model_regs [0:2];

    always #5 clk = ~clk;

    axi4lite_slave_regs dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (aresetn),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .status_in     (status_in),
        .ctrl_out      (ctrl_out),
        .data_out      (data_out),
        .data_wr_pulse (data_wr_pulse)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [1:0] idx, input logic [7:0] d, input logic s);
        if (idx != 2'd3 && s) model_regs[idx] = d;
    endfunction

    function automatic logic [7:0] model_read(input logic [1:0] idx, input logic [7:0] st);
        return (idx == 2'd3) ? st : model_regs[idx];
    endfunction

    // Presents one write from W_IDLE; mode 0 = together, 1 = AW first, 2 = W first.
    task automatic axi_write(input logic [1:0] idx, input logic [7:0] d, input logic s,
                             input int mode, input int gap);
        case (mode)
            0: begin
                awaddr = idx; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
                step(); awvalid = 1'b0; wvalid = 1'b0;
            end
            1: begin
                awaddr = idx; awvalid = 1'b1; step(); awvalid = 1'b0;
                repeat (gap) step();
                wdata = d; wstrb = s; wvalid = 1'b1; step(); wvalid = 1'b0;
            end
            default: begin
                wdata = d; wstrb = s; wvalid = 1'b1; step(); wvalid = 1'b0;
                repeat (gap) step();
                awaddr = idx; awvalid = 1'b1; step(); awvalid = 1'b0;
            end
        endcase
    endtask

    task automatic accept_b(input int delay);
        repeat (delay) step();
        bready = 1'b1; step(); bready = 1'b0;
    endtask

    task automatic start_read(input logic [1:0] idx);
        araddr = idx; arvalid = 1'b1; step(); arvalid = 1'b0;
    endtask

    task automatic accept_r(input int delay);
        repeat (delay) step();
        rready = 1'b1; step(); rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) step();
        checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL rst_readies_low: got %b want 000", {awready, wready, arready}); end
        checks++; if ({bvalid, rvalid, data_wr_pulse} !== 3'b000) begin errors++; $display("FAIL rst_valids: got %b want 000", {bvalid, rvalid, data_wr_pulse}); end
        checks++; if ({ctrl_out, data_out, rdata, bresp, rresp} !== 28'h0) begin errors++; $display("FAIL rst_values: ctrl=%h data=%h rdata=%h bresp=%b rresp=%b want zeros", ctrl_out, data_out, rdata, bresp, rresp); end
        aresetn = 1'b1;
        step();
        checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL rst_readies_release: got %b want 111", {awready, wready, arready}); end
        for (int i = 0; i < 3; i++) model_regs[i] = 8'h00;
        $display("txn reset");
    endtask

    task automatic test_write_addr_first();
        logic [7:0] rd;
        awaddr = 2'd1; awvalid = 1'b1; step(); awvalid = 1'b0;
        checks++; if ({awready, wready, bvalid} !== 3'b010) begin errors++; $display("FAIL waf_after_aw: aw/w/b got %b want 010", {awready, wready, bvalid}); end
        step();
        wdata = 8'hA5; wstrb = 1'b1; wvalid = 1'b1; step(); wvalid = 1'b0;
        model_write(2'd1, 8'hA5, 1'b1);
        checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL waf_data: got %h want a5", data_out); end
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL waf_bresp: bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        checks++; if (data_wr_pulse !== 1'b1) begin errors++; $display("FAIL waf_pulse_high: got %b want 1", data_wr_pulse); end
        step();
        checks++; if (data_wr_pulse !== 1'b0) begin errors++; $display("FAIL waf_pulse_once: got %b want 0", data_wr_pulse); end
        checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL waf_bvalid_hold: got %b want 1", bvalid); end
        accept_b(0);
        checks++; if ({bvalid, awready, wready} !== 3'b011) begin errors++; $display("FAIL waf_idle: b/aw/w got %b want 011", {bvalid, awready, wready}); end
        start_read(2'd1); rd = rdata; accept_r(0);
        checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL waf_readback: got %h want a5", rd); end
        $display("txn write-addr-first idx1 a5");
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        axi_write(2'd2, 8'h3C, 1'b1, 0, 0);
        model_write(2'd2, 8'h3C, 1'b1);
        checks++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin errors++; $display("FAIL sim_bvalid: bvalid=%b bresp=%b want 1/00", bvalid, bresp); end
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 2'd0; wdata = 8'hEE; wstrb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({bvalid, awready, wready} !== 3'b100) begin errors++; $display("FAIL sim_hold cyc%0d: b/aw/w got %b want 100", i, {bvalid, awready, wready}); end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        accept_b(0);
        checks++; if (ctrl_out !== model_regs[0]) begin errors++; $display("FAIL sim_no_extra_write: ctrl got %h want %h", ctrl_out, model_regs[0]); end
        start_read(2'd2); rd = rdata; accept_r(0);
        checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL sim_scratch: got %h want 3c", rd); end
        $display("txn simultaneous idx2 3c");
    endtask

    task automatic test_slverr();
        axi_write(2'd3, 8'hFF, 1'b1, 0, 0);
        checks++; if (bresp !== 2'b10) begin errors++; $display("FAIL slv_bresp: got %b want 10", bresp); end
        checks++; if (data_wr_pulse !== 1'b0) begin errors++; $display("FAIL slv_pulse: got %b want 0", data_wr_pulse); end
        checks++; if (ctrl_out !== model_regs[0] || data_out !== model_regs[1]) begin errors++; $display("FAIL slv_regs: ctrl=%h data=%h want %h %h", ctrl_out, data_out, model_regs[0], model_regs[1]); end
        accept_b(1);
        checks++; if (data_wr_pulse !== 1'b0) begin errors++; $display("FAIL slv_pulse_later: got %b want 0", data_wr_pulse); end
        $display("txn write idx3 ff slverr");
    endtask

    task automatic test_read_status();
        status_in = 8'h5A;
        start_read(2'd3);
        status_in = 8'h00;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h5A || rresp !== 2'b00) begin errors++; $display("FAIL rd_status: rvalid=%b rdata=%h rresp=%b want 1/5a/00", rvalid, rdata, rresp); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if ({rvalid, arready} !== 2'b10 || rdata !== 8'h5A) begin errors++; $display("FAIL rd_hold cyc%0d: rvalid/arready=%b rdata=%h want 10/5a", i, {rvalid, arready}, rdata); end
        end
        accept_r(0);
        checks++; if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL rd_release: rvalid/arready=%b want 01", {rvalid, arready}); end
        $display("txn read idx3 5a");
    endtask

    task automatic test_read_write_collision();
        logic [7:0] rd;
        axi_write(2'd0, 8'h22, 1'b1, 0, 0); accept_b(0);
        model_write(2'd0, 8'h22, 1'b1);
        awaddr = 2'd0; wdata = 8'h11; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 2'd0; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++; if (rvalid !== 1'b1 || rdata !== 8'h22) begin errors++; $display("FAIL col_old_value: rvalid=%b rdata=%h want 1/22", rvalid, rdata); end
        checks++; if (ctrl_out !== 8'h11 || bvalid !== 1'b1) begin errors++; $display("FAIL col_commit: ctrl=%h bvalid=%b want 11/1", ctrl_out, bvalid); end
        bready = 1'b1; rready = 1'b1; step(); bready = 1'b0; rready = 1'b0;
        model_write(2'd0, 8'h11, 1'b1);
        start_read(2'd0); rd = rdata; accept_r(0);
        checks++; if (rd !== 8'h11) begin errors++; $display("FAIL col_new_value: got %h want 11", rd); end
        $display("txn read/write collision idx0");
    endtask

    task automatic test_reset_mid();
        awaddr = 2'd0; awvalid = 1'b1; step(); awvalid = 1'b0;
        checks++; if ({awready, wready} !== 2'b01) begin errors++; $display("FAIL rmid_in_addr: aw/w got %b want 01", {awready, wready}); end
        aresetn = 1'b0;
        wdata = 8'h77; wstrb = 1'b1; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        checks++; if ({awready, wready, arready, bvalid} !== 4'b0000) begin errors++; $display("FAIL rmid_during: aw/w/ar/b got %b want 0000", {awready, wready, arready, bvalid}); end
        checks++; if (ctrl_out !== 8'h00 || data_out !== 8'h00) begin errors++; $display("FAIL rmid_clear: ctrl=%h data=%h want 00 00", ctrl_out, data_out); end
        aresetn = 1'b1;
        step();
        for (int i = 0; i < 3; i++) model_regs[i] = 8'h00;
        checks++; if ({awready, wready, arready, bvalid} !== 4'b1110) begin errors++; $display("FAIL rmid_after: aw/w/ar/b got %b want 1110", {awready, wready, arready, bvalid}); end
        step();
        checks++; if (bvalid !== 1'b0 || ctrl_out !== 8'h00) begin errors++; $display("FAIL rmid_no_commit: bvalid=%b ctrl=%h want 0/00", bvalid, ctrl_out); end
        $display("txn reset mid-write");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] idx;
            logic [7:0] d, exp;
            logic       s;
            int         mode, gap;
            idx  = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            s    = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 0) begin
                axi_write(idx, d, s, mode, gap);
                checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL rnd%0d_bvalid: got %b want 1", n, bvalid); end
                checks++; if (bresp !== ((idx == 2'd3) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rnd%0d_bresp: got %b idx=%0d", n, bresp, idx); end
                checks++; if (data_wr_pulse !== (s && idx == 2'd1)) begin errors++; $display("FAIL rnd%0d_pulse: got %b idx=%0d strb=%b", n, data_wr_pulse, idx, s); end
                model_write(idx, d, s);
                checks++; if (ctrl_out !== model_regs[0] || data_out !== model_regs[1]) begin errors++; $display("FAIL rnd%0d_regs: ctrl=%h data=%h want %h %h", n, ctrl_out, data_out, model_regs[0], model_regs[1]); end
                accept_b($urandom_range(0, 2));
                checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rnd%0d_bdone: got %b want 0", n, bvalid); end
                $display("txn %0d write idx=%0d data=%h strb=%b mode=%0d", n, idx, d, s, mode);
            end else begin
                status_in = 8'($urandom);
                exp = model_read(idx, status_in);
                start_read(idx);
                status_in = 8'($urandom);
                checks++; if (rvalid !== 1'b1 || rdata !== exp) begin errors++; $display("FAIL rnd%0d_read: rvalid=%b rdata=%h want 1/%h idx=%0d", n, rvalid, rdata, exp, idx); end
                accept_r($urandom_range(0, 2));
                $display("txn %0d read idx=%0d data=%h", n, idx, exp);
            end
        end
    endtask

    initial begin
        aresetn = 1'b0; awaddr = 2'd0; awvalid = 1'b0; wdata = 8'h00; wstrb = 1'b0; wvalid = 1'b0;
        bready = 1'b0; araddr = 2'd0; arvalid = 1'b0; rready = 1'b0; status_in = 8'h00;
        test_reset();
        test_write_addr_first();
        test_back_to_back();
        test_slverr();
        test_read_status();
        test_read_write_collision();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
